// File: rtl/matrix_storage_reader.sv
// rtl/matrix_storage_reader.sv - row read-out sequencer for matrix storages with credit-limited output FIFO
// Defining MATRIX_READER_ABORT_EN adds the abort input.
module matrix_storage_reader #(
   parameter int DATA_WIDTH   = 48,
   parameter int INDEX_WIDTH  = 32,
   parameter int READ_LATENCY = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                   clk_clk,
   input  logic                   reset_reset,
   input  logic                   start,
   input  logic [INDEX_WIDTH-1:0] layer_index,
   input  logic [INDEX_WIDTH-1:0] row_count,
`ifdef MATRIX_READER_ABORT_EN
   input  logic                   abort,
`endif
   output logic                   busy,
   output logic                   done,
   output logic [INDEX_WIDTH-1:0] read_layer_index,
   output logic [INDEX_WIDTH-1:0] read_row_index,
   output logic                   is_read,
   input  logic [DATA_WIDTH-1:0]  read_data,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic [INDEX_WIDTH-1:0] out_row_index,
   output logic                   out_last,
   output logic                   out_valid,
   input  logic                   out_ready
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(READ_LATENCY + FIFO_DEPTH + 2);
   localparam int EW = DATA_WIDTH + INDEX_WIDTH + 1;
   localparam logic [AW:0] CNT_ONE = 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t                  state;
   logic [INDEX_WIDTH-1:0]  rows_l;
   logic [INDEX_WIDTH-1:0]  next_row;
   logic [INDEX_WIDTH-1:0]  last_row;

   logic [READ_LATENCY-1:0] pipe_valid;
   logic [INDEX_WIDTH-1:0]  pipe_row [READ_LATENCY];

   logic [EW-1:0]           fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic [AW:0]             fifo_count;
   logic [EW-1:0]           head;

   logic                    push;
   logic                    pop;
   logic                    abort_now;
   logic                    credit;
   logic                    drained;
   logic [CW-1:0]           outstanding;

`ifdef MATRIX_READER_ABORT_EN
   assign abort_now = busy & abort;
`else
   assign abort_now = 1'b0;
`endif

   assign last_row = rows_l - INDEX_WIDTH'(1);
   assign pop      = out_valid & out_ready;
   assign push     = pipe_valid[READ_LATENCY-1] & ~abort_now;

   // Every issued read owns a FIFO slot until popped, so counting them all makes overflow impossible.
   always_comb begin
      outstanding = CW'(fifo_count) + CW'(is_read);
      for (int i = 0; i < READ_LATENCY; i++) begin
         outstanding = outstanding + CW'(pipe_valid[i]);
      end
   end

   assign credit  = outstanding < CW'(FIFO_DEPTH);
   assign drained = (pipe_valid == '0) && !is_read &&
                    ((fifo_count == '0) || ((fifo_count == CNT_ONE) && pop));

   assign head          = fifo_mem[rd_ptr];
   assign out_valid     = (fifo_count != '0);
   assign out_data      = out_valid ? head[EW-1:INDEX_WIDTH+1] : '0;
   assign out_row_index = out_valid ? head[INDEX_WIDTH:1] : '0;
   assign out_last      = out_valid & head[0];

   always_ff @(posedge clk_clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {read_data, pipe_row[READ_LATENCY-1],
                              pipe_row[READ_LATENCY-1] == last_row};
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else if (abort_now) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_ONE;
            2'b01:   fifo_count <= fifo_count - CNT_ONE;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Return pipe tracks which storage cycles carry a requested word and for which row.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         pipe_valid <= '0;
         for (int i = 0; i < READ_LATENCY; i++) pipe_row[i] <= '0;
      end else begin
         pipe_valid[0] <= is_read & ~abort_now;
         pipe_row[0]   <= read_row_index;
         for (int i = READ_LATENCY - 1; i > 0; i--) begin
            pipe_valid[i] <= pipe_valid[i-1] & ~abort_now;
            pipe_row[i]   <= pipe_row[i-1];
         end
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state            <= S_IDLE;
         busy             <= 1'b0;
         done             <= 1'b0;
         is_read          <= 1'b0;
         read_layer_index <= '0;
         read_row_index   <= '0;
         rows_l           <= '0;
         next_row         <= '0;
      end else begin
         done    <= 1'b0;
         is_read <= 1'b0;
         if (abort_now) begin
            state            <= S_IDLE;
            busy             <= 1'b0;
            read_layer_index <= '0;
            read_row_index   <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     rows_l           <= row_count;
                     busy             <= 1'b1;
                     read_layer_index <= layer_index;
                     read_row_index   <= '0;
                     if (row_count == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                     end else begin
                        is_read  <= 1'b1;
                        next_row <= INDEX_WIDTH'(1);
                        state    <= (row_count == INDEX_WIDTH'(1)) ? S_DRAIN : S_ISSUE;
                     end
                  end
               end
               S_ISSUE: begin
                  if (credit) begin
                     is_read        <= 1'b1;
                     read_row_index <= next_row;
                     next_row       <= next_row + INDEX_WIDTH'(1);
                     if (next_row == last_row) state <= S_DRAIN;
                  end
               end
               S_DRAIN: begin
                  if (drained) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end
               end
               default: begin
                  state            <= S_IDLE;
                  busy             <= 1'b0;
                  read_layer_index <= '0;
                  read_row_index   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_matrix_storage_reader.sv
// tb/tb_matrix_storage_reader.sv - directed self-checking bench for matrix_storage_reader
module tb_matrix_storage_reader;
`ifdef MATRIX_READER_ABORT_EN
   localparam int L = 2;
`else
   localparam int L = 1;
`endif
   localparam int DW = 48;
   localparam int IW = 32;

   logic          clk_clk = 1'b0;
   logic          reset_reset = 1'b1;
   logic          start = 1'b0;
   logic          out_ready = 1'b0;
   logic [IW-1:0] layer_index = '0;
   logic [IW-1:0] row_count = '0;
   logic          busy, done, is_read, out_last, out_valid;
   logic [IW-1:0] read_layer_index, read_row_index, out_row_index;
   logic [DW-1:0] read_data, out_data;
`ifdef MATRIX_READER_ABORT_EN
   logic          abort = 1'b0;
`endif

   int total = 0;
   int bad = 0;

   always #5 clk_clk = ~clk_clk;

   matrix_storage_reader #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .READ_LATENCY(L), .FIFO_DEPTH(4)) dut (
      .clk_clk(clk_clk),
      .reset_reset(reset_reset),
      .start(start),
      .layer_index(layer_index),
      .row_count(row_count),
`ifdef MATRIX_READER_ABORT_EN
      .abort(abort),
`endif
      .busy(busy),
      .done(done),
      .read_layer_index(read_layer_index),
      .read_row_index(read_row_index),
      .is_read(is_read),
      .read_data(read_data),
      .out_data(out_data),
      .out_row_index(out_row_index),
      .out_last(out_last),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   function automatic logic [DW-1:0] word_of(input logic [IW-1:0] r);
      logic [15:0] b;
      b = 16'(r * 3);
      return {b + 16'd1, b + 16'd2, b + 16'd3};
   endfunction

   // storage model: fixed latency, garbage when no read is returning
   logic [L-1:0]  mv = '0;
   logic [IW-1:0] mrow [L];
   always @(posedge clk_clk) begin
      mv[0]   <= is_read;
      mrow[0] <= read_row_index;
      for (int i = 1; i < L; i++) begin
         mv[i]   <= mv[i-1];
         mrow[i] <= mrow[i-1];
      end
   end
   assign read_data = mv[L-1] ? word_of(mrow[L-1]) : 48'hDEAD_BEEF_CAFE;

   int            cyc = 0, st_cyc = -1, done_cnt = 0, done_cyc = -1;
   int            ov_cnt = 0, busy_cnt = 0, stab_err = 0;
   logic [IW-1:0] rd_rows[$], rd_layers[$], o_rows[$];
   int            rd_cyc[$], o_cyc[$];
   logic [DW-1:0] o_data[$];
   logic          o_last[$];
   logic          held_v = 1'b0, held_l = 1'b0;
   logic [DW-1:0] held_d = '0;
   logic [IW-1:0] held_r = '0;

   always @(negedge clk_clk) begin
      cyc++;
      if (start) st_cyc = cyc;
      if (is_read) begin
         rd_rows.push_back(read_row_index);
         rd_layers.push_back(read_layer_index);
         rd_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
         o_rows.push_back(out_row_index);
         o_data.push_back(out_data);
         o_last.push_back(out_last);
         o_cyc.push_back(cyc);
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (out_valid) ov_cnt++;
      if (busy) busy_cnt++;
      if (held_v && (out_valid !== 1'b1 || out_data !== held_d ||
                     out_row_index !== held_r || out_last !== held_l)) stab_err++;
      held_v = out_valid && !out_ready && !reset_reset;
      held_d = out_data;
      held_r = out_row_index;
      held_l = out_last;
   end

   task automatic tick();
      @(posedge clk_clk);
      #1;
   endtask

   task automatic clear_log();
      rd_rows.delete(); rd_layers.delete(); rd_cyc.delete();
      o_rows.delete(); o_data.delete(); o_last.delete(); o_cyc.delete();
      done_cnt = 0; done_cyc = -1; ov_cnt = 0; busy_cnt = 0; stab_err = 0; st_cyc = -1;
   endtask

   task automatic start_run(input logic [IW-1:0] layer, input logic [IW-1:0] rows);
      layer_index = layer;
      row_count   = rows;
      start       = 1'b1;
      tick();
      start       = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         tick();
         n++;
      end
      ok = (done_cnt != 0);
      repeat (3) tick();
   endtask

   task automatic test_reset();
      repeat (2) tick();
      total++;
      if ({busy, done, is_read, out_valid, out_last} !== 5'b0)
         $display("FAIL reset_flags: got busy=%b done=%b is_read=%b out_valid=%b out_last=%b, want all 0",
                  busy, done, is_read, out_valid, out_last);
      total++;
      if (out_data !== '0 || out_row_index !== '0 || read_layer_index !== '0 || read_row_index !== '0)
         $display("FAIL reset_buses: got data=%h row=%0d rl=%0d rr=%0d, want 0", out_data, out_row_index,
                  read_layer_index, read_row_index);
      reset_reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      bit ok;
      clear_log();
      out_ready = 1'b1;
      start_run(2, 3);
      wait_done(60, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL basic_done: got no done, want one pulse"); end
      total++;
      if (rd_rows.size() !== 3) begin bad++; $display("FAIL basic_read_count: got %0d want 3", rd_rows.size()); end
      for (int i = 0; i < rd_rows.size(); i++) begin
         total++;
         if (rd_rows[i] !== 32'(i) || rd_layers[i] !== 32'd2 || rd_cyc[i] !== st_cyc + 1 + i) begin
            bad++;
            $display("FAIL basic_read[%0d]: got row=%0d layer=%0d cyc=%0d, want row=%0d layer=2 cyc=%0d",
                     i, rd_rows[i], rd_layers[i], rd_cyc[i], i, st_cyc + 1 + i);
         end
      end
      total++;
      if (o_rows.size() !== 3) begin bad++; $display("FAIL basic_word_count: got %0d want 3", o_rows.size()); end
      for (int i = 0; i < o_rows.size(); i++) begin
         total++;
         if (o_rows[i] !== 32'(i) || o_data[i] !== word_of(32'(i)) || o_last[i] !== (i == 2)) begin
            bad++;
            $display("FAIL basic_word[%0d]: got row=%0d data=%h last=%b, want row=%0d data=%h last=%b",
                     i, o_rows[i], o_data[i], o_last[i], i, word_of(32'(i)), (i == 2));
         end
      end
      total++;
      if (o_cyc.size() == 0 || rd_cyc.size() == 0 || o_cyc[0] !== rd_cyc[0] + L + 1) begin
         bad++;
         $display("FAIL basic_latency: got first word cyc=%0d, want read cyc + %0d", o_cyc.size() ? o_cyc[0] : -1, L + 1);
      end
      total++;
      if (done_cnt !== 1 || o_cyc.size() == 0 || done_cyc <= o_cyc[o_cyc.size()-1] || busy !== 1'b0) begin
         bad++;
         $display("FAIL basic_done_pulse: got count=%0d cyc=%0d busy=%b, want 1 pulse after last pop, busy 0",
                  done_cnt, done_cyc, busy);
      end
   endtask

   task automatic test_stall();
      bit ok;
      clear_log();
      out_ready = 1'b0;
      start_run(3, 8);
      repeat (12) tick();
      total++;
      if (rd_rows.size() !== 4) begin bad++; $display("FAIL stall_credit: got %0d reads, want 4", rd_rows.size()); end
      total++;
      if (out_valid !== 1'b1 || out_row_index !== 32'd0 || out_data !== word_of(0) || out_last !== 1'b0) begin
         bad++;
         $display("FAIL stall_head: got valid=%b row=%0d data=%h last=%b, want 1 0 %h 0",
                  out_valid, out_row_index, out_data, out_last, word_of(0));
      end
      out_ready = 1'b1;
      wait_done(80, ok);
      total++;
      if (!ok || done_cnt !== 1) begin bad++; $display("FAIL stall_done: got %0d pulses, want 1", done_cnt); end
      total++;
      if (rd_rows.size() !== 8 || o_rows.size() !== 8)
         begin bad++; $display("FAIL stall_counts: got reads=%0d words=%0d, want 8 8", rd_rows.size(), o_rows.size()); end
      for (int i = 0; i < o_rows.size(); i++) begin
         total++;
         if (o_rows[i] !== 32'(i) || o_data[i] !== word_of(32'(i)) || o_last[i] !== (i == 7) || rd_rows[i] !== 32'(i)) begin
            bad++;
            $display("FAIL stall_word[%0d]: got row=%0d data=%h last=%b, want row=%0d data=%h", i, o_rows[i],
                     o_data[i], o_last[i], i, word_of(32'(i)));
         end
      end
      total++;
      if (stab_err !== 0) begin bad++; $display("FAIL stall_hold: got %0d changes while stalled, want 0", stab_err); end
   endtask

   task automatic test_empty();
      clear_log();
      start_run(7, 0);
      repeat (4) tick();
      total++;
      if (done_cnt !== 1 || done_cyc !== st_cyc + 1) begin
         bad++;
         $display("FAIL empty_done: got count=%0d cyc=%0d, want 1 at cyc=%0d", done_cnt, done_cyc, st_cyc + 1);
      end
      total++;
      if (rd_rows.size() !== 0 || ov_cnt !== 0 || busy_cnt !== 1) begin
         bad++;
         $display("FAIL empty_quiet: got reads=%0d valid_cycles=%0d busy_cycles=%0d, want 0 0 1",
                  rd_rows.size(), ov_cnt, busy_cnt);
      end
   endtask

   task automatic test_start_while_busy();
      bit ok;
      clear_log();
      out_ready = 1'b1;
      start_run(1, 6);
      tick();
      start_run(5, 2);
      wait_done(80, ok);
      total++;
      if (!ok || done_cnt !== 1 || rd_rows.size() !== 6 || o_rows.size() !== 6) begin
         bad++;
         $display("FAIL busy_start_counts: got done=%0d reads=%0d words=%0d, want 1 6 6",
                  done_cnt, rd_rows.size(), o_rows.size());
      end
      for (int i = 0; i < rd_rows.size(); i++) begin
         total++;
         if (rd_layers[i] !== 32'd1 || rd_rows[i] !== 32'(i)) begin
            bad++;
            $display("FAIL busy_start_read[%0d]: got layer=%0d row=%0d, want layer=1 row=%0d", i, rd_layers[i], rd_rows[i], i);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int n = 0;
      clear_log();
      out_ready = 1'b1;
      start_run(1, 8);
      while (o_rows.size() < 2 && n < 40) begin
         @(negedge clk_clk);
         #1;
         n++;
      end
      total++;
      if (o_rows.size() < 2) begin bad++; $display("FAIL rst_mid_wait: got %0d words, want 2", o_rows.size()); end
      reset_reset = 1'b1;
      #1;
      total++;
      if ({busy, done, is_read, out_valid, out_last} !== 5'b0 || out_data !== '0 || out_row_index !== '0 ||
          read_layer_index !== '0 || read_row_index !== '0) begin
         bad++;
         $display("FAIL rst_mid_outputs: got busy=%b is_read=%b valid=%b data=%h rr=%0d, want all 0",
                  busy, is_read, out_valid, out_data, read_row_index);
      end
      tick();
      reset_reset = 1'b0;
      repeat (2) tick();
      total++;
      if (done_cnt !== 0) begin bad++; $display("FAIL rst_mid_nodone: got %0d done pulses, want 0", done_cnt); end
      clear_log();
      start_run(1, 4);
      wait_done(60, ok);
      total++;
      if (!ok || o_rows.size() !== 4 || rd_rows.size() !== 4) begin
         bad++;
         $display("FAIL rst_mid_restart: got done=%b words=%0d reads=%0d, want 1 4 4", ok, o_rows.size(), rd_rows.size());
      end
      for (int i = 0; i < o_rows.size(); i++) begin
         total++;
         if (o_rows[i] !== 32'(i) || o_data[i] !== word_of(32'(i)) || o_last[i] !== (i == 3)) begin
            bad++;
            $display("FAIL rst_mid_word[%0d]: got row=%0d data=%h, want row=%0d data=%h", i, o_rows[i], o_data[i],
                     i, word_of(32'(i)));
         end
      end
   endtask

`ifdef MATRIX_READER_ABORT_EN
   task automatic test_abort();
      bit ok;
      int n = 0;
      int ov_before, rd_before;
      clear_log();
      out_ready = 1'b1;
      start_run(4, 8);
      while (o_rows.size() < 1 && n < 40) begin
         @(negedge clk_clk);
         #1;
         n++;
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || is_read !== 1'b0) begin
         bad++;
         $display("FAIL abort_next: got busy=%b valid=%b is_read=%b, want 0 0 0", busy, out_valid, is_read);
      end
      ov_before = ov_cnt;
      rd_before = rd_rows.size();
      repeat (10) tick();
      total++;
      if (ov_cnt !== ov_before || done_cnt !== 0 || rd_rows.size() !== rd_before) begin
         bad++;
         $display("FAIL abort_quiet: got valid_cycles=%0d done=%0d reads=%0d, want %0d 0 %0d",
                  ov_cnt, done_cnt, rd_rows.size(), ov_before, rd_before);
      end
      clear_log();
      start_run(6, 5);
      wait_done(60, ok);
      total++;
      if (!ok || done_cnt !== 1 || o_rows.size() !== 5) begin
         bad++;
         $display("FAIL abort_restart: got done=%0d words=%0d, want 1 5", done_cnt, o_rows.size());
      end
      for (int i = 0; i < o_rows.size(); i++) begin
         total++;
         if (o_rows[i] !== 32'(i) || o_data[i] !== word_of(32'(i)) || o_last[i] !== (i == 4)) begin
            bad++;
            $display("FAIL abort_word[%0d]: got row=%0d data=%h, want row=%0d data=%h", i, o_rows[i], o_data[i],
                     i, word_of(32'(i)));
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_empty();
      test_start_while_busy();
      test_reset_mid();
`ifdef MATRIX_READER_ABORT_EN
      test_abort();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
